// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared opcode and FSM state definitions for the SPI command decoder
package common_pkg;

    typedef enum logic [2:0] {
        OP_WRITE_AT   = 3'b000,
        OP_READ_AT    = 3'b001,
        OP_WRITE_NEXT = 3'b010,
        OP_READ_NEXT  = 3'b011
    } opcode_e;

    typedef enum logic [2:0] {
        ST_CMD     = 3'd0,
        ST_ADDR_HI = 3'd1,
        ST_ADDR_LO = 3'd2,
        ST_DATA    = 3'd3,
        ST_BUS     = 3'd4,
        ST_IGNORE  = 3'd5
    } state_e;

    function automatic logic [2:0] cmd_opcode(input logic [7:0] cmd);
        return cmd[7:5];
    endfunction

endpackage

// File: rtl/spi_cmd_decoder.sv
// rtl/spi_cmd_decoder.sv - decodes SPI command frames into single-byte bus reads and writes
module spi_cmd_decoder
    import common_pkg::*;
#(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  sys_clock_i,
    input  logic                  sys_reset_n_i,
    input  logic                  spi_frame_start_i,
    input  logic                  spi_rx_valid_i,
    input  logic [7:0]            spi_rx_data_i,
    output logic [7:0]            spi_tx_data_o,
    output logic                  spi_tx_valid_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [7:0]            bus_wr_data_o,
    input  logic                  bus_ack_i,
    input  logic [7:0]            bus_rd_data_i
);

    state_e                  r_state;
    state_e                  w_next_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_a16;
    logic [7:0]              r_addr_hi;
    logic                    r_we;
    logic [7:0]              r_wr_data;
    logic [7:0]              r_tx_data;
    logic                    r_tx_valid;

    logic                    w_byte;
    logic                    w_ack;
    logic [2:0]              w_op;
    logic                    w_op_next;
    logic [ADDR_WIDTH-1:0]   w_next_addr;
    logic [ADDR_WIDTH-1:0]   w_new_addr;

    // A frame start in the same cycle as a byte discards that byte.
    assign w_byte      = spi_rx_valid_i & ~spi_frame_start_i;
    assign w_ack       = (r_state == ST_BUS) & bus_ack_i;
    assign w_op        = cmd_opcode(spi_rx_data_i);
    assign w_op_next   = (w_op == OP_WRITE_NEXT) | (w_op == OP_READ_NEXT);
    assign w_next_addr = r_addr + ADDR_WIDTH'(1);
    assign w_new_addr  = ADDR_WIDTH'({r_a16, r_addr_hi, spi_rx_data_i});

    always_ff @(posedge sys_clock_i or negedge sys_reset_n_i) begin
        if (!sys_reset_n_i) begin
            r_state <= ST_CMD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (r_state == ST_BUS) begin
            // Frame start cannot abort a bus transaction; only the ack leaves BUS.
            if (bus_ack_i) begin
                w_next_state = ST_CMD;
            end
        end else if (spi_frame_start_i) begin
            w_next_state = ST_CMD;
        end else if (spi_rx_valid_i) begin
            case (r_state)
                ST_CMD: begin
                    case (w_op)
                        OP_WRITE_AT, OP_READ_AT: w_next_state = ST_ADDR_HI;
                        OP_WRITE_NEXT:           w_next_state = ST_DATA;
                        OP_READ_NEXT:            w_next_state = ST_BUS;
                        default:                 w_next_state = ST_IGNORE;
                    endcase
                end
                ST_ADDR_HI: w_next_state = ST_ADDR_LO;
                ST_ADDR_LO: w_next_state = r_we ? ST_DATA : ST_BUS;
                ST_DATA:    w_next_state = ST_BUS;
                default:    w_next_state = r_state;
            endcase
        end
    end

    always_comb begin
        bus_req_o = 1'b0;
        if (r_state == ST_BUS) begin
            bus_req_o = 1'b1;
        end
    end

    assign bus_we_o       = r_we;
    assign bus_addr_o     = r_addr;
    assign bus_wr_data_o  = r_wr_data;
    assign spi_tx_data_o  = r_tx_data;
    assign spi_tx_valid_o = r_tx_valid;

    always_ff @(posedge sys_clock_i or negedge sys_reset_n_i) begin
        if (!sys_reset_n_i) begin
            r_addr     <= '0;
            r_a16      <= 1'b0;
            r_addr_hi  <= 8'h00;
            r_we       <= 1'b0;
            r_wr_data  <= 8'h00;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
        end else begin
            r_tx_valid <= 1'b0;
            if (w_byte) begin
                case (r_state)
                    ST_CMD: begin
                        r_we  <= (w_op == OP_WRITE_AT) | (w_op == OP_WRITE_NEXT);
                        r_a16 <= spi_rx_data_i[0];
                        if (w_op_next) begin
                            r_addr <= w_next_addr;
                        end
                    end
                    ST_ADDR_HI: r_addr_hi <= spi_rx_data_i;
                    // Address register only commits once the low byte completes it.
                    ST_ADDR_LO: r_addr    <= w_new_addr;
                    ST_DATA:    r_wr_data <= spi_rx_data_i;
                    default: ;
                endcase
            end
            if (w_ack && !r_we) begin
                r_tx_data  <= bus_rd_data_i;
                r_tx_valid <= 1'b1;
            end
        end
    end

endmodule
